// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and codes for the data-memory access controller
package dmem_pkg;

   // Access sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ADDR = 2'b01,
      DATA = 2'b10,
      DONE = 2'b11
   } dmem_state_t;

   // Bus size encodings (already adjusted upstream)
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_TRI  = 2'b11;

   // Unaligned-load merge selectors
   localparam logic [1:0] LWLR_NONE = 2'b00;
   localparam logic [1:0] LWL       = 2'b01;
   localparam logic [1:0] LWR       = 2'b10;

endpackage

// File: rtl/lwlr_merge.sv
// rtl/lwlr_merge.sv - combinational LWL/LWR merge of bus read data with the old rt value
module lwlr_merge
   import dmem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [31:0] rt_val,
   input  logic [1:0]  lwlr,
   input  logic [1:0]  lwlr_off,
   output logic [31:0] res
);

   logic [4:0] lsh;
   logic [4:0] rsh;

   // Shift amounts in bits: LWL moves the fetched bytes up by 3-k lanes, LWR down by k lanes
   always_comb begin
      lsh = {2'd3 - lwlr_off, 3'b000};
      rsh = {lwlr_off, 3'b000};
   end

   // Fetched bytes overwrite their lanes of rt; the remaining lanes keep rt
   always_comb begin
      res = rdata;
      case (lwlr)
         LWL:     res = (rdata << lsh) | (rt_val & ~(32'hFFFF_FFFF << lsh));
         LWR:     res = (rdata >> rsh) | (rt_val & ~(32'hFFFF_FFFF >> rsh));
         default: res = rdata;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage access sequencer for the req/addr_ok/data_ok bus; LWL/LWR merge under DMEM_ACCESS_CTRL_LWLR_EN
module dmem_access_ctrl
   import dmem_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_req,
   input  logic        mem_wr,
   input  logic [1:0]  mem_size,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [1:0]  lwlr,
   input  logic [1:0]  lwlr_off,
   input  logic [31:0] rt_val,
   input  logic        flush,
   input  logic        wb_stall,
   output logic        mem_stall,
   output logic [31:0] mem_rdata,
   output logic        mem_rvalid,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   dmem_state_t state;
   dmem_state_t state_nxt;
   logic        cancel;
   logic        cancel_nxt;
   logic [31:0] rdata_q;
   logic [31:0] merged;

`ifdef DMEM_ACCESS_CTRL_LWLR_EN
   lwlr_merge u_lwlr_merge (
      .rdata    (data_rdata),
      .rt_val   (rt_val),
      .lwlr     (lwlr),
      .lwlr_off (lwlr_off),
      .res      (merged)
   );
`else
   logic lwlr_unused;
   assign lwlr_unused = ^{lwlr, lwlr_off, rt_val};
   assign merged      = data_rdata;
`endif

   // State, cancel flag and load-data holding register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= IDLE;
         cancel  <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state  <= state_nxt;
         cancel <= cancel_nxt;
         if (state == DATA && data_data_ok) begin
            rdata_q <= merged;
         end
      end
   end

   // Next state; a flush mid-transaction only marks it cancelled, the bus still finishes it
   always_comb begin
      state_nxt  = state;
      cancel_nxt = cancel;
      case (state)
         IDLE: begin
            if (mem_req && !flush) begin
               state_nxt = data_addr_ok ? DATA : ADDR;
            end
         end
         ADDR: begin
            if (flush) cancel_nxt = 1'b1;
            if (data_addr_ok) state_nxt = DATA;
         end
         DATA: begin
            if (flush) cancel_nxt = 1'b1;
            if (data_data_ok) begin
               state_nxt  = (cancel || flush) ? IDLE : DONE;
               cancel_nxt = 1'b0;
            end
         end
         DONE: begin
            if (!wb_stall || flush) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pipeline and bus outputs; request never retracted once in ADDR
   always_comb begin
      data_req   = (state == IDLE && mem_req && !flush) || (state == ADDR);
      mem_stall  = mem_req && (state != DONE) && !flush;
      mem_rvalid = (state == DONE) && !mem_wr;
      mem_rdata  = rdata_q;
      data_wr    = mem_wr;
      data_size  = mem_size;
      data_addr  = mem_addr;
      data_wdata = mem_wdata;
   end

   // Bus must only return data while a transaction is in its data phase
   always_ff @(posedge clk) begin
      if (resetn) begin
         assert (!(data_data_ok && state != DATA));
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  lwlr;
   logic [1:0]  lwlr_off;
   logic [31:0] rt_val;
   logic        flush;
   logic        wb_stall;
   logic        mem_stall;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   int passed = 0;
   int total  = 0;

   dmem_access_ctrl dut (
      .clk          (clk),
      .resetn       (resetn),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_size     (mem_size),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .lwlr         (lwlr),
      .lwlr_off     (lwlr_off),
      .rt_val       (rt_val),
      .flush        (flush),
      .wb_stall     (wb_stall),
      .mem_stall    (mem_stall),
      .mem_rdata    (mem_rdata),
      .mem_rvalid   (mem_rvalid),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
   endtask

   // Load with addr_ok in the issue cycle and data_ok in the next one
   task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] rd,
                          input logic [1:0] lw, input logic [1:0] off, input logic [31:0] rt,
                          input logic [31:0] exp);
      @(negedge clk);
      mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'b10; mem_addr = addr;
      lwlr = lw; lwlr_off = off; rt_val = rt; data_addr_ok = 1'b1;
      #1 chk({tag, "_stall0"}, 32'(mem_stall), 32'd1);
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd;
      #1 chk({tag, "_stall1"}, 32'(mem_stall), 32'd1);
      @(negedge clk);
      data_data_ok = 1'b0;
      #1 chk({tag, "_rvalid"}, 32'(mem_rvalid), 32'd1);
      chk({tag, "_rdata"}, mem_rdata, exp);
      chk({tag, "_done_stall"}, 32'(mem_stall), 32'd0);
      @(negedge clk);
      mem_req = 1'b0; lwlr = 2'b00;
      #1 chk({tag, "_idle"}, 32'(mem_rvalid), 32'd0);
   endtask

   initial begin
      resetn = 1'b0; mem_req = 1'b0; mem_wr = 1'b0; mem_size = 2'b10; mem_addr = 32'h0;
      mem_wdata = 32'h0; lwlr = 2'b00; lwlr_off = 2'b00; rt_val = 32'h0; flush = 1'b0;
      wb_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1 chk("rst_stall", 32'(mem_stall), 32'd0);
      chk("rst_req", 32'(data_req), 32'd0);
      chk("rst_rvalid", 32'(mem_rvalid), 32'd0);
      chk("rst_rdata", mem_rdata, 32'h0);
      resetn = 1'b1;

      // 1: word load, minimum latency
      do_load("t1", 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 2'b00, 32'h0, 32'hDEAD_BEEF);

      // 2: store with addr_ok delayed three cycles
      @(negedge clk);
      mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h0000_0204; mem_wdata = 32'hCAFE_F00D;
      for (int i = 0; i < 4; i++) begin
         data_addr_ok = (i == 3);
         #1 chk("t2_req", 32'(data_req), 32'd1);
         chk("t2_addr", data_addr, 32'h0000_0204);
         chk("t2_wdata", data_wdata, 32'hCAFE_F00D);
         chk("t2_stall", 32'(mem_stall), 32'd1);
         @(negedge clk);
      end
      data_addr_ok = 1'b0; data_data_ok = 1'b1;
      #1 chk("t2_data_req", 32'(data_req), 32'd0);
      chk("t2_data_stall", 32'(mem_stall), 32'd1);
      @(negedge clk);
      data_data_ok = 1'b0;
      #1 chk("t2_done_stall", 32'(mem_stall), 32'd0);
      chk("t2_done_rvalid", 32'(mem_rvalid), 32'd0);
      @(negedge clk);
      mem_req = 1'b0; mem_wr = 1'b0;

      // flush in IDLE issues nothing
      @(negedge clk);
      mem_req = 1'b1; flush = 1'b1; mem_addr = 32'h0000_0280;
      #1 chk("fi_req", 32'(data_req), 32'd0);
      chk("fi_stall", 32'(mem_stall), 32'd0);
      @(negedge clk);
      mem_req = 1'b0; flush = 1'b0;
      #1 chk("fi_idle_req", 32'(data_req), 32'd0);

      // 3: flush in DATA, data_ok two cycles later
      @(negedge clk);
      mem_req = 1'b1; mem_addr = 32'h0000_0300; data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0; flush = 1'b1;
      #1 chk("t3_flush_stall", 32'(mem_stall), 32'd0);
      chk("t3_flush_req", 32'(data_req), 32'd0);
      @(negedge clk);
      flush = 1'b0; mem_req = 1'b0;
      #1 chk("t3_wait_rvalid", 32'(mem_rvalid), 32'd0);
      @(negedge clk);
      data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
      #1 chk("t3_dok_rvalid", 32'(mem_rvalid), 32'd0);
      @(negedge clk);
      data_data_ok = 1'b0;
      #1 chk("t3_after_rvalid", 32'(mem_rvalid), 32'd0);
      // next request issues normally from IDLE; 4: held by wb_stall in DONE
      @(negedge clk);
      mem_req = 1'b1; mem_addr = 32'h0000_0400; data_addr_ok = 1'b1;
      #1 chk("t3_next_req", 32'(data_req), 32'd1);
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
      @(negedge clk);
      data_data_ok = 1'b0; wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t4_hold_rvalid", 32'(mem_rvalid), 32'd1);
         chk("t4_hold_rdata", mem_rdata, 32'h1234_5678);
         chk("t4_hold_req", 32'(data_req), 32'd0);
         @(negedge clk);
      end
      wb_stall = 1'b0;
      #1 chk("t4_release_rvalid", 32'(mem_rvalid), 32'd1);
      @(negedge clk);
      mem_req = 1'b0;
      #1 chk("t4_idle_rvalid", 32'(mem_rvalid), 32'd0);

      // data_ok and flush together in DATA count as cancelled
      @(negedge clk);
      mem_req = 1'b1; mem_addr = 32'h0000_0500; data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b1; flush = 1'b1; data_rdata = 32'h7777_7777;
      @(negedge clk);
      data_data_ok = 1'b0; flush = 1'b0; mem_req = 1'b0;
      #1 chk("df_rvalid", 32'(mem_rvalid), 32'd0);

      // 5: LWL / LWR merge
`ifdef DMEM_ACCESS_CTRL_LWLR_EN
      do_load("t5_lwl1", 32'h0000_0600, 32'h1122_3344, 2'b01, 2'd1, 32'hAABB_CCDD, 32'h3344_CCDD);
      do_load("t5_lwl2", 32'h0000_0600, 32'h1122_3344, 2'b01, 2'd2, 32'hAABB_CCDD, 32'h2233_44DD);
      do_load("t5_lwr2", 32'h0000_0600, 32'h1122_3344, 2'b10, 2'd2, 32'hAABB_CCDD, 32'hAABB_1122);
      do_load("t5_lwr3", 32'h0000_0600, 32'h1122_3344, 2'b10, 2'd3, 32'hAABB_CCDD, 32'hAABB_CC11);
`else
      do_load("t5_lwl1", 32'h0000_0600, 32'h1122_3344, 2'b01, 2'd1, 32'hAABB_CCDD, 32'h1122_3344);
      do_load("t5_lwr2", 32'h0000_0600, 32'h1122_3344, 2'b10, 2'd2, 32'hAABB_CCDD, 32'h1122_3344);
`endif

      // 6: reset mid-DATA, bus data arriving during reset is dropped
      @(negedge clk);
      mem_req = 1'b1; mem_addr = 32'h0000_0700; data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0; resetn = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h9999_9999;
      @(negedge clk);
      resetn = 1'b1; data_data_ok = 1'b0; mem_req = 1'b0;
      #1 chk("t6_stall", 32'(mem_stall), 32'd0);
      chk("t6_req", 32'(data_req), 32'd0);
      chk("t6_rvalid", 32'(mem_rvalid), 32'd0);
      chk("t6_rdata", mem_rdata, 32'h0);
      @(negedge clk);
      #1 chk("t6_idle_rvalid", 32'(mem_rvalid), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
